// File: rtl/spdif_pkg.sv
// Shared S/PDIF subframe definitions: preamble codes, slot positions,
// FSM state encoding and subframe assembly helpers.
package spdif_pkg;

    localparam int FRAMES_PER_BLOCK = 192;
    localparam int AUDIO_BITS       = 24;
    localparam int CS_BITS          = 32;

    localparam int SLOT_V = 24;
    localparam int SLOT_U = 25;
    localparam int SLOT_C = 26;
    localparam int SLOT_P = 27;

    typedef enum logic [1:0] {
        PRE_B = 2'b00,
        PRE_M = 2'b01,
        PRE_W = 2'b10
    } preamble_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LEFT,
        ST_RIGHT
    } sched_state_e;

    function automatic logic even_parity(input logic [SLOT_P-1:0] bits);
        return ^bits;
    endfunction

    function automatic logic [SLOT_P:0] build_subframe(input logic [AUDIO_BITS-1:0] audio,
                                                       input logic v,
                                                       input logic c);
        logic [SLOT_P:0] s;
        s                 = '0;
        s[AUDIO_BITS-1:0] = audio;
        s[SLOT_V]         = v;
        s[SLOT_U]         = 1'b0;
        s[SLOT_C]         = c;
        s[SLOT_P]         = even_parity(s[SLOT_P-1:0]);
        return s;
    endfunction

    // Only the first 32 channel-status bits are programmable; the rest of the block is 0.
    function automatic logic cs_bit(input logic [CS_BITS-1:0] cs, input logic [7:0] idx);
        return (idx < 8'(CS_BITS)) ? cs[idx[4:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/spdif_frame_scheduler_if.sv
// Sample-source and encoder-side signals of the S/PDIF frame scheduler.
// master = the scheduler, slave = the surrounding system.
interface spdif_frame_scheduler_if;
    logic        enable;
    logic [23:0] sample_left;
    logic [23:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] cs_word;
    logic        sf_valid;
    logic        enc_ready;
    logic [1:0]  sf_preamble;
    logic [27:0] sf_data;
    logic [7:0]  frame_index;
    logic        underrun;

    modport master (
        input  enable, sample_left, sample_right, sample_valid, cs_word, enc_ready,
        output sample_ready, sf_valid, sf_preamble, sf_data, frame_index, underrun
    );

    modport slave (
        output enable, sample_left, sample_right, sample_valid, cs_word, enc_ready,
        input  sample_ready, sf_valid, sf_preamble, sf_data, frame_index, underrun
    );
endinterface

// File: rtl/spdif_frame_scheduler.sv
// Turns sample pairs into left/right S/PDIF subframes paced by the encoder
// handshake; owns frame numbering, preambles, C/V/P bits and underrun fill.
//
// state    | meaning
// ST_IDLE  | parked, no subframe presented
// ST_FETCH | sample_ready high, pair (or zero fill) captured
// ST_LEFT  | left subframe presented, waiting for enc_ready
// ST_RIGHT | right subframe presented, waiting for enc_ready
module spdif_frame_scheduler #(
    parameter int AUDIO_WIDTH      = 24,
    parameter int FRAMES_PER_BLOCK = spdif_pkg::FRAMES_PER_BLOCK
) (
    input logic                     clk,
    input logic                     rst,
    spdif_frame_scheduler_if.master bus
);
    import spdif_pkg::*;

    sched_state_e           state, state_nxt;
    logic                   sf_valid, sf_valid_nxt;
    preamble_e              sf_preamble, sf_preamble_nxt;
    logic [27:0]            sf_data, sf_data_nxt;
    logic [7:0]             frame_index, frame_index_nxt;
    logic                   sample_ready, sample_ready_nxt;
    logic                   underrun, underrun_nxt;
    logic [AUDIO_WIDTH-1:0] hold_right, hold_right_nxt;
    logic                   v_hold, v_hold_nxt;
    logic [31:0]            cs_hold, cs_hold_nxt;
    logic [AUDIO_WIDTH-1:0] left_audio;
    logic                   xfer;

    assign xfer = sf_valid && bus.enc_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            sf_valid     <= 1'b0;
            sf_preamble  <= PRE_B;
            sf_data      <= '0;
            frame_index  <= '0;
            sample_ready <= 1'b0;
            underrun     <= 1'b0;
            hold_right   <= '0;
            v_hold       <= 1'b0;
            cs_hold      <= '0;
        end else begin
            state        <= state_nxt;
            sf_valid     <= sf_valid_nxt;
            sf_preamble  <= sf_preamble_nxt;
            sf_data      <= sf_data_nxt;
            frame_index  <= frame_index_nxt;
            sample_ready <= sample_ready_nxt;
            underrun     <= underrun_nxt;
            hold_right   <= hold_right_nxt;
            v_hold       <= v_hold_nxt;
            cs_hold      <= cs_hold_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        sf_valid_nxt     = sf_valid;
        sf_preamble_nxt  = sf_preamble;
        sf_data_nxt      = sf_data;
        frame_index_nxt  = frame_index;
        sample_ready_nxt = 1'b0;
        underrun_nxt     = 1'b0;
        hold_right_nxt   = hold_right;
        v_hold_nxt       = v_hold;
        cs_hold_nxt      = cs_hold;
        left_audio       = '0;

        unique case (state)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_nxt        = ST_FETCH;
                    sample_ready_nxt = 1'b1;
                end
            end
            ST_FETCH: begin
                state_nxt   = ST_LEFT;
                cs_hold_nxt = bus.cs_word;
                // The left subframe is built straight from the inputs so it can
                // be presented on the very next cycle.
                if (bus.sample_valid) begin
                    left_audio     = bus.sample_left;
                    hold_right_nxt = bus.sample_right;
                    v_hold_nxt     = 1'b0;
                end else begin
                    hold_right_nxt = '0;
                    v_hold_nxt     = 1'b1;
                    underrun_nxt   = 1'b1;
                end
                sf_valid_nxt    = 1'b1;
                sf_preamble_nxt = (frame_index == 8'd0) ? PRE_B : PRE_M;
                sf_data_nxt     = build_subframe(left_audio, !bus.sample_valid,
                                                 cs_bit(bus.cs_word, frame_index));
            end
            ST_LEFT: begin
                if (xfer) begin
                    state_nxt       = ST_RIGHT;
                    sf_preamble_nxt = PRE_W;
                    sf_data_nxt     = build_subframe(hold_right, v_hold,
                                                     cs_bit(cs_hold, frame_index));
                end
            end
            ST_RIGHT: begin
                if (xfer) begin
                    sf_valid_nxt    = 1'b0;
                    frame_index_nxt = (frame_index == 8'(FRAMES_PER_BLOCK - 1)) ?
                                      8'd0 : frame_index + 8'd1;
                    if (bus.enable) begin
                        state_nxt        = ST_FETCH;
                        sample_ready_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.sf_valid     = sf_valid;
    assign bus.sf_preamble  = sf_preamble;
    assign bus.sf_data      = sf_data;
    assign bus.frame_index  = frame_index;
    assign bus.sample_ready = sample_ready;
    assign bus.underrun     = underrun;

endmodule
